// File: rtl/rv32i_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core MEM stage and a DMA/debug master.
// Optional busy-wait abort enabled by defining DMEM_ARB_TIMEOUT_EN.
module rv32i_dmem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_req,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  input  logic        i_core_wr,
  input  logic [3:0]  i_core_mask,
  output logic [31:0] o_core_rdata,
  output logic        o_core_ack,
  output logic        o_core_err,
  output logic        o_core_stall,
  input  logic        i_dma_req,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  input  logic        i_dma_wr,
  input  logic [3:0]  i_dma_mask,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_ack,
  output logic        o_dma_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wr,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  state_t state, state_nxt;
  logic   owner;
  logic   last_grant;
  logic   any_req;
  logic   pick_dma;
  logic   abort;
  logic   finish;

  assign o_core_stall = i_core_req & ~o_core_ack;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    any_req  = i_core_req | i_dma_req;
    pick_dma = i_dma_req & (~i_core_req | (last_grant == OWN_CORE));
    finish   = (state == BUSY) & (i_mem_ack | abort);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (i_mem_ack || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter is zero whenever not BUSY, so every transaction starts from a clean count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              wait_cnt <= '0;
    else if (state != BUSY)    wait_cnt <= '0;
    else if (!i_mem_ack)       wait_cnt <= wait_cnt + 8'd1;
  end

  assign abort = (state == BUSY) && !i_mem_ack && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_core_err <= 1'b0;
      o_dma_err  <= 1'b0;
    end else if (finish) begin
      o_core_err <= abort & (owner == OWN_CORE);
      o_dma_err  <= abort & (owner == OWN_DMA);
    end else if (state == DONE) begin
      o_core_err <= 1'b0;
      o_dma_err  <= 1'b0;
    end
  end
`else
  logic [7:0] unused_timeout;

  // Without the abort path BUSY waits forever; TIMEOUT is kept only for port/parameter compatibility.
  assign unused_timeout = 8'(TIMEOUT);
  assign abort          = 1'b0;
  assign o_core_err     = 1'b0;
  assign o_dma_err      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner        <= OWN_CORE;
      last_grant   <= OWN_DMA;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_wr     <= 1'b0;
      o_mem_mask   <= '0;
      o_core_ack   <= 1'b0;
      o_core_rdata <= '0;
      o_dma_ack    <= 1'b0;
      o_dma_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick_dma;
            last_grant <= pick_dma;
            o_mem_req  <= 1'b1;
            if (pick_dma) begin
              o_mem_addr  <= i_dma_addr;
              o_mem_wdata <= i_dma_wdata;
              o_mem_wr    <= i_dma_wr;
              o_mem_mask  <= i_dma_mask;
            end else begin
              o_mem_addr  <= i_core_addr;
              o_mem_wdata <= i_core_wdata;
              o_mem_wr    <= i_core_wr;
              o_mem_mask  <= i_core_mask;
            end
          end
        end
        BUSY: begin
          if (finish) begin
            o_mem_req <= 1'b0;
            if (owner == OWN_DMA) begin
              o_dma_ack <= 1'b1;
              if (abort)          o_dma_rdata <= '0;
              else if (!o_mem_wr) o_dma_rdata <= i_mem_rdata;
            end else begin
              o_core_ack <= 1'b1;
              if (abort)          o_core_rdata <= '0;
              else if (!o_mem_wr) o_core_rdata <= i_mem_rdata;
            end
          end
        end
        DONE: begin
          o_core_ack <= 1'b0;
          o_dma_ack  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Self-checking bench for rv32i_dmem_arbiter: directed scenarios plus a randomized two-master stream
// checked against a transaction-level memory/arbitration model. Honours DMEM_ARB_TIMEOUT_EN.
module tb_rv32i_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_core_req, i_core_wr, i_dma_req, i_dma_wr;
  logic [31:0] i_core_addr, i_core_wdata, i_dma_addr, i_dma_wdata;
  logic [3:0]  i_core_mask, i_dma_mask;
  logic [31:0] o_core_rdata, o_dma_rdata;
  logic        o_core_ack, o_core_err, o_core_stall, o_dma_ack, o_dma_err;
  logic        o_mem_req, o_mem_wr;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;

  always #5 clk = ~clk;

  rv32i_dmem_arbiter #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_req(i_core_req), .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
    .i_core_wr(i_core_wr), .i_core_mask(i_core_mask),
    .o_core_rdata(o_core_rdata), .o_core_ack(o_core_ack), .o_core_err(o_core_err),
    .o_core_stall(o_core_stall),
    .i_dma_req(i_dma_req), .i_dma_addr(i_dma_addr), .i_dma_wdata(i_dma_wdata),
    .i_dma_wr(i_dma_wr), .i_dma_mask(i_dma_mask),
    .o_dma_rdata(o_dma_rdata), .o_dma_ack(o_dma_ack), .o_dma_err(o_dma_err),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wr(o_mem_wr), .o_mem_mask(o_mem_mask),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
  );

  int checks = 0;
  int errors = 0;

  // Memory model and the transaction it is currently serving.
  logic [31:0] mem_words [logic [31:0]];
  int          mem_lat = 1;
  bit          mem_mute = 1'b0;
  bit          mem_force = 1'b0;
  int          busy_cnt = 0;
  bit          prev_req = 1'b0;
  logic        g_core, g_dma, g_wr;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_mask;
  logic        last_win;
  logic [31:0] exp_rd [2];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic mem_step();
    logic [31:0] w;
    if (mem_force) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'hBAD0_BAD0;
    end else if (o_mem_req) begin
      if (!prev_req) begin
        g_core = i_core_req; g_dma = i_dma_req;
        g_addr = o_mem_addr; g_wdata = o_mem_wdata; g_wr = o_mem_wr; g_mask = o_mem_mask;
        busy_cnt = 0;
      end
      busy_cnt++;
      if (!mem_mute && busy_cnt == mem_lat) begin
        i_mem_ack = 1'b1;
        if (g_wr) begin
          w = mem_read(g_addr);
          for (int b = 0; b < 4; b++) if (g_mask[b]) w[b*8 +: 8] = g_wdata[b*8 +: 8];
          mem_words[g_addr] = w;
          i_mem_rdata = $urandom;
        end else begin
          i_mem_rdata = mem_read(g_addr);
        end
      end else begin
        i_mem_ack = 1'b0;
      end
    end else begin
      i_mem_ack = 1'b0;
    end
    prev_req = o_mem_req;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mem_step();
  endtask

  task automatic clear_inputs();
    i_core_req = 0; i_core_wr = 0; i_core_addr = 0; i_core_wdata = 0; i_core_mask = 0;
    i_dma_req = 0; i_dma_wr = 0; i_dma_addr = 0; i_dma_wdata = 0; i_dma_mask = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    i_mem_ack = 0; i_mem_rdata = 0; mem_mute = 0; mem_force = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_req = 0; last_win = 1'b1; exp_rd[0] = 0; exp_rd[1] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    i_core_req = 1; i_dma_req = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_mem_req, o_core_ack, o_dma_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_hold_idle: req/acks=%b expected 000", {o_mem_req, o_core_ack, o_dma_ack});
    end
    clear_inputs();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({o_mem_req, o_mem_wr, o_mem_mask, o_core_ack, o_dma_ack, o_core_err, o_dma_err, o_core_stall} !== 11'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {o_mem_req, o_mem_wr, o_mem_mask, o_core_ack, o_dma_ack, o_core_err, o_dma_err, o_core_stall});
    end
    checks++;
    if ({o_mem_addr, o_mem_wdata, o_core_rdata, o_dma_rdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {o_mem_addr, o_mem_wdata, o_core_rdata, o_dma_rdata});
    end
  endtask

  task automatic test_core_load();
    int req_hi = 0, acks = 0, ack_t = -1;
    mem_words[32'h100] = 32'hDEADBEEF;
    mem_lat = 2;
    i_core_addr = 32'h100; i_core_mask = 4'hF; i_core_wr = 0; i_core_wdata = $urandom; i_core_req = 1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (o_mem_req) req_hi++;
      if (o_dma_ack) begin
        checks++; errors++; $display("FAIL core_load_dma_ack: got 1 expected 0 at t=%0d", t);
      end
      if (o_core_ack) begin
        acks++; ack_t = t;
        checks++;
        if (o_core_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL core_load_rdata: got %h expected deadbeef", o_core_rdata);
        end
        checks++;
        if (o_core_stall !== 1'b0) begin
          errors++; $display("FAIL core_load_stall_ack: got %b expected 0", o_core_stall);
        end
        exp_rd[0] = 32'hDEADBEEF; last_win = 1'b0;
        i_core_req = 0;
      end else if (ack_t < 0) begin
        checks++;
        if (o_core_stall !== 1'b1) begin
          errors++; $display("FAIL core_load_stall: got %b expected 1 at t=%0d", o_core_stall, t);
        end
      end
    end
    checks++;
    if (acks != 1 || ack_t != 3) begin
      errors++; $display("FAIL core_load_ack: got %0d acks at t=%0d expected 1 at t=3", acks, ack_t);
    end
    checks++;
    if (req_hi != 2) begin
      errors++; $display("FAIL core_load_memreq: high %0d cycles expected 2", req_hi);
    end
  endtask

  task automatic test_dma_store();
    int acks = 0, ack_t = -1;
    mem_lat = 1;
    i_dma_addr = 32'h204; i_dma_wdata = 32'h0000AB00; i_dma_mask = 4'b0010; i_dma_wr = 1; i_dma_req = 1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) begin
        checks++;
        if ({o_mem_req, o_mem_wr, o_mem_mask, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, 4'b0010, 32'h204, 32'h0000AB00}) begin
          errors++; $display("FAIL dma_store_bus: got req=%b wr=%b mask=%b addr=%h wdata=%h expected 1 1 0010 204 0000ab00",
            o_mem_req, o_mem_wr, o_mem_mask, o_mem_addr, o_mem_wdata);
        end
      end
      if (o_core_ack) begin
        checks++; errors++; $display("FAIL dma_store_core_ack: got 1 expected 0");
      end
      if (o_dma_ack) begin
        acks++; ack_t = t;
        checks++;
        if (o_dma_rdata !== exp_rd[1] || o_dma_err !== 1'b0) begin
          errors++; $display("FAIL dma_store_rdata: got %h err=%b expected %h err=0", o_dma_rdata, o_dma_err, exp_rd[1]);
        end
        last_win = 1'b1;
        i_dma_req = 0;
      end
    end
    checks++;
    if (acks != 1 || ack_t != 2) begin
      errors++; $display("FAIL dma_store_latency: got %0d acks at edge %0d expected 1 at edge 2", acks, ack_t);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [4];
    int n = 0;
    logic who;
    logic [31:0] a;
    exp_order = '{0, 1, 0, 1};
    do_reset();
    mem_lat = 1;
    i_core_addr = 32'h300; i_core_wr = 0; i_core_mask = 4'hF; i_core_req = 1;
    i_dma_addr = 32'h400; i_dma_wr = 0; i_dma_mask = 4'hF; i_dma_req = 1;
    for (int t = 0; t < 40 && n < 4; t++) begin
      tick();
      if (o_core_ack && o_dma_ack) begin
        checks++; errors++; $display("FAIL rr_double_ack: both acks high");
      end else if (o_core_ack || o_dma_ack) begin
        who = o_dma_ack;
        a = who ? i_dma_addr : i_core_addr;
        checks++;
        if (int'(who) != exp_order[n]) begin
          errors++; $display("FAIL rr_order: grant %0d went to %0d expected %0d", n, who, exp_order[n]);
        end
        checks++;
        if (g_addr !== a || (who ? o_dma_rdata : o_core_rdata) !== mem_read(a)) begin
          errors++; $display("FAIL rr_addr_data: addr=%h rdata=%h expected addr=%h rdata=%h",
            g_addr, who ? o_dma_rdata : o_core_rdata, a, mem_read(a));
        end
        exp_rd[who] = mem_read(a);
        last_win = who;
        if (who) i_dma_addr += 4; else i_core_addr += 4;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count: got %0d completions expected 4", n);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_reset_busy();
    int acks = 0, ack_t = -1;
    mem_mute = 1;
    i_core_addr = 32'h104; i_core_wr = 0; i_core_mask = 4'hF; i_core_req = 1;
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mem_req, o_mem_wr, o_mem_mask, o_core_ack, o_dma_ack, o_core_err, o_dma_err} !== 9'd0 ||
        {o_mem_addr, o_mem_wdata, o_core_rdata, o_dma_rdata} !== 128'd0) begin
      errors++; $display("FAIL reset_busy_outputs: req=%b addr=%h crd=%h drd=%h expected all 0",
        o_mem_req, o_mem_addr, o_core_rdata, o_dma_rdata);
    end
    i_core_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    last_win = 1'b1; exp_rd[0] = 0; exp_rd[1] = 0;
    mem_mute = 0;
    mem_force = 1; mem_step(); mem_force = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({o_core_ack, o_dma_ack, o_mem_req} !== 3'b000) begin
        errors++; $display("FAIL reset_busy_stray_ack: ack/ack/req=%b expected 000", {o_core_ack, o_dma_ack, o_mem_req});
      end
    end
    mem_lat = 1;
    i_core_addr = 32'h108; i_core_req = 1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (o_core_ack) begin
        acks++; ack_t = t; i_core_req = 0; last_win = 0; exp_rd[0] = o_core_rdata;
      end
    end
    checks++;
    if (acks != 1 || ack_t != 2) begin
      errors++; $display("FAIL reset_busy_resume: got %0d acks at edge %0d expected 1 at edge 2", acks, ack_t);
    end
  endtask

`ifdef DMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int req_hi = 0, acks = 0;
    mem_mute = 1;
    i_core_addr = 32'h500; i_core_wr = 0; i_core_mask = 4'hF; i_core_req = 1;
    for (int t = 0; t < 10 && acks == 0; t++) begin
      tick();
      if (o_mem_req) req_hi++;
      if (o_core_ack) begin
        acks++;
        checks++;
        if ({o_core_err, o_core_rdata, o_mem_req, o_dma_err} !== {1'b1, 32'd0, 1'b0, 1'b0} || req_hi != 4) begin
          errors++; $display("FAIL timeout_abort: err=%b rdata=%h memreq=%b busy=%0d expected err=1 rdata=0 memreq=0 busy=4",
            o_core_err, o_core_rdata, o_mem_req, req_hi);
        end
        i_core_req = 0; last_win = 0; exp_rd[0] = 0;
      end
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL timeout_no_ack: got %0d acks expected 1", acks);
    end
    mem_mute = 0;
    tick();
  endtask

  task automatic test_ack_at_timeout();
    int req_hi = 0, acks = 0;
    mem_lat = 4;
    i_core_addr = 32'h504; i_core_wr = 0; i_core_mask = 4'hF; i_core_req = 1;
    for (int t = 0; t < 10 && acks == 0; t++) begin
      tick();
      if (o_mem_req) req_hi++;
      if (o_core_ack) begin
        acks++;
        checks++;
        if (o_core_err !== 1'b0 || o_core_rdata !== mem_read(32'h504) || req_hi != 4) begin
          errors++; $display("FAIL ack_at_timeout: err=%b rdata=%h busy=%0d expected err=0 rdata=%h busy=4",
            o_core_err, o_core_rdata, req_hi, mem_read(32'h504));
        end
        i_core_req = 0; last_win = 0; exp_rd[0] = mem_read(32'h504);
      end
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL ack_at_timeout_count: got %0d acks expected 1", acks);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    mem_mute = 1;
    i_core_addr = 32'h500; i_core_wr = 0; i_core_mask = 4'hF; i_core_req = 1;
    for (int t = 0; t < 100; t++) begin
      tick();
      if ({o_core_stall, o_core_ack, o_core_err, o_mem_req} !== 4'b1001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_timeout_wait: %0d bad cycles expected 0 (stall=%b err=%b)", bad, o_core_stall, o_core_err);
    end
    do_reset();
  endtask
`endif

  task automatic test_random();
    logic        req_r [2];
    logic [31:0] addr_r [2], wdata_r [2];
    logic        wr_r [2];
    logic [3:0]  mask_r [2];
    int          gap [2], waitc [2];
    int          done = 0;
    logic        who, exp_who;
    logic [31:0] exp_d, got_d;
    for (int r = 0; r < 2; r++) begin
      req_r[r] = 0; addr_r[r] = 0; wdata_r[r] = 0; wr_r[r] = 0; mask_r[r] = 0; gap[r] = 0; waitc[r] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!o_mem_req) mem_lat = $urandom_range(1, 4);
      tick();
      checks++;
      if (o_core_stall !== (req_r[0] & ~o_core_ack)) begin
        errors++; $display("FAIL rand_stall: got %b expected %b", o_core_stall, req_r[0] & ~o_core_ack);
      end
      if (o_core_ack && o_dma_ack) begin
        checks++; errors++; $display("FAIL rand_double_ack: both acks high");
      end else if (o_core_ack || o_dma_ack) begin
        who = o_dma_ack;
        exp_who = (g_core && g_dma) ? ~last_win : g_dma;
        got_d = who ? o_dma_rdata : o_core_rdata;
        exp_d = wr_r[who] ? exp_rd[who] : mem_read(addr_r[who]);
        checks++;
        if (who !== exp_who) begin
          errors++; $display("FAIL rand_grant: got %0d expected %0d", who, exp_who);
        end
        checks++;
        if (g_addr !== addr_r[who] || g_wr !== wr_r[who] || (wr_r[who] && {g_mask, g_wdata} !== {mask_r[who], wdata_r[who]})) begin
          errors++; $display("FAIL rand_bus: addr=%h wr=%b mask=%h wdata=%h expected %h %b %h %h",
            g_addr, g_wr, g_mask, g_wdata, addr_r[who], wr_r[who], mask_r[who], wdata_r[who]);
        end
        checks++;
        if (got_d !== exp_d || (who ? o_dma_err : o_core_err) !== 1'b0) begin
          errors++; $display("FAIL rand_rdata: requester %0d got %h err=%b expected %h err=0",
            who, got_d, who ? o_dma_err : o_core_err, exp_d);
        end
        exp_rd[who] = exp_d;
        last_win = who;
        req_r[who] = 0;
        gap[who] = $urandom_range(0, 2);
        done++;
      end
      for (int r = 0; r < 2; r++) begin
        if (req_r[r]) begin
          waitc[r]++;
          if (waitc[r] > 40) begin
            checks++; errors++; $display("FAIL rand_starve: requester %0d waited %0d cycles expected <=40", r, waitc[r]);
            req_r[r] = 0;
          end
        end else if (gap[r] > 0) begin
          gap[r]--;
        end else if ($urandom_range(0, 2) == 0) begin
          addr_r[r]  = 32'h800 + {$urandom_range(0, 7), 2'b00};
          wr_r[r]    = 1'($urandom_range(0, 1));
          mask_r[r]  = wr_r[r] ? 4'($urandom_range(1, 15)) : 4'hF;
          wdata_r[r] = $urandom;
          req_r[r]   = 1;
          waitc[r]   = 0;
        end
      end
      i_core_req = req_r[0]; i_core_addr = addr_r[0]; i_core_wdata = wdata_r[0]; i_core_wr = wr_r[0]; i_core_mask = mask_r[0];
      i_dma_req = req_r[1]; i_dma_addr = addr_r[1]; i_dma_wdata = wdata_r[1]; i_dma_wr = wr_r[1]; i_dma_mask = mask_r[1];
    end
    checks++;
    if (done < 20) begin
      errors++; $display("FAIL rand_throughput: got %0d completions expected >=20", done);
    end
    clear_inputs();
    repeat (6) tick();
  endtask

  initial begin
    clear_inputs();
    i_mem_ack = 0; i_mem_rdata = 0;
    test_reset();
    test_core_load();
    test_dma_store();
    test_round_robin();
    test_reset_busy();
`ifdef DMEM_ARB_TIMEOUT_EN
    test_timeout();
    test_ack_at_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
